feeder_a: RTL and testbench

FEEDER_A -- requirements
Module: feeder_a

---
 rtl/feeder_a.sv | 95 +++++++++
 tb/tb_feeder_a.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/feeder_a.sv
// Feeds matrix A into a systolic array as a row-skewed wavefront:
// row i sees column t-i at step t, from a snapshot taken on start.
module feeder_a #(
    parameter int DATA_WIDTH = 8,
    parameter int ARRAY_W    = 5,
    parameter int ARRAY_L    = 2
) (
    input  logic                                             clk,
    input  logic                                             reset_n,
    input  logic                                             start,
    input  logic                                             stall,
    input  logic [0:ARRAY_W-1][0:ARRAY_L-1][DATA_WIDTH-1:0]  data_rom,
    output logic [0:ARRAY_W-1][DATA_WIDTH-1:0]               out_data,
    output logic [0:ARRAY_W-1]                               out_valid,
    output logic                                             busy,
    output logic                                             done
);

    localparam int STEPS = ARRAY_W + ARRAY_L - 1;
    localparam int TW    = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam logic [TW-1:0] T_LAST = TW'(STEPS - 1);

    typedef enum logic [1:0] {
        IDLE,
        FEED,
        DONE
    } state_t;

    typedef logic [0:ARRAY_W-1][0:ARRAY_L-1][DATA_WIDTH-1:0] snap_t;

    state_t         state_q, state_d;
    logic [TW-1:0]  t_q, t_d;
    snap_t          snap_q, snap_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            t_q     <= '0;
            snap_q  <= '0;
        end else begin
            state_q <= state_d;
            t_q     <= t_d;
            snap_q  <= snap_d;
        end
    end

    always_comb begin
        state_d = state_q;
        t_d     = t_q;
        snap_d  = snap_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    snap_d  = data_rom;
                    t_d     = '0;
                    state_d = FEED;
                end
            end
            FEED: begin
                if (!stall) begin
                    if (t_q == T_LAST) begin
                        state_d = DONE;
                    end else begin
                        t_d = t_q + 1'b1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Stall freezes the wavefront; data stays visible but is not qualified.
    always_comb begin
        out_data  = '0;
        out_valid = '0;
        busy      = (state_q == FEED);
        done      = (state_q == DONE);
        if (state_q == FEED) begin
            for (int i = 0; i < ARRAY_W; i++) begin
                for (int j = 0; j < ARRAY_L; j++) begin
                    if (int'(t_q) == i + j) begin
                        out_data[i]  = snap_q[i][j];
                        out_valid[i] = !stall;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_feeder_a.sv
// Randomized and directed bench for feeder_a against a pass-level model,
// with a second 1x1 instance for the minimum-size boundary.
module tb_feeder_a;

    localparam int W = 5;
    localparam int L = 2;

    logic clk = 1'b0;
    logic reset_n;
    logic start, stall;
    logic [0:W-1][0:L-1][7:0] rom;
    logic [0:W-1][7:0] out_data;
    logic [0:W-1] out_valid;
    logic busy, done;

    logic start1, stall1;
    logic [0:0][0:0][7:0] rom1;
    logic [0:0][7:0] out_data1;
    logic [0:0] out_valid1;
    logic busy1, done1;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    feeder_a #(.DATA_WIDTH(8), .ARRAY_W(W), .ARRAY_L(L)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .stall(stall),
        .data_rom(rom), .out_data(out_data), .out_valid(out_valid),
        .busy(busy), .done(done)
    );

    feeder_a #(.DATA_WIDTH(8), .ARRAY_W(1), .ARRAY_L(1)) dut1 (
        .clk(clk), .reset_n(reset_n), .start(start1), .stall(stall1),
        .data_rom(rom1), .out_data(out_data1), .out_valid(out_valid1),
        .busy(busy1), .done(done1)
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Pass-level model: a pass is "idle", "feeding at step p" or "done".
    int m_mode;
    int m_p;
    logic [7:0] m_snap [W][L];

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_mode = 0;
            m_p = 0;
            for (int i = 0; i < W; i++)
                for (int j = 0; j < L; j++) m_snap[i][j] = 8'h00;
        end else if (m_mode == 0) begin
            if (start) begin
                for (int i = 0; i < W; i++)
                    for (int j = 0; j < L; j++) m_snap[i][j] = rom[i][j];
                m_p = 0;
                m_mode = 1;
            end
        end else if (m_mode == 1) begin
            if (!stall) begin
                if (m_p == W + L - 2) m_mode = 2;
                else m_p = m_p + 1;
            end
        end else begin
            m_mode = 0;
        end
    end

    always @(negedge clk) begin
        logic [8:0] exp_row;
        int d;
        chk("busy", busy, m_mode == 1);
        chk("done", done, m_mode == 2);
        for (int i = 0; i < W; i++) begin
            d = m_p - i;
            exp_row = 9'h000;
            if (m_mode == 1 && d >= 0 && d < L)
                exp_row = {!stall, m_snap[i][d]};
            chk($sformatf("row%0d", i), {out_valid[i], out_data[i]}, exp_row);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(output int at);
        bit seen = 0;
        at = -1;
        for (int k = 0; k < 40 && !seen; k++) begin
            tick();
            @(negedge clk);
            if (done) begin
                seen = 1;
                at = cyc;
            end
        end
        n_chk++;
        if (!seen) begin
            n_fail++;
            $display("FAIL done_timeout: got no done expected done");
        end
    endtask

    task automatic basic_pass();
        int c0, c1;
        tick();
        for (int i = 0; i < W; i++)
            for (int j = 0; j < L; j++) rom[i][j] = 8'(10 * i + j);
        start = 1'b1;
        tick();
        start = 1'b0;
        c0 = cyc;
        @(negedge clk);
        chk("t0_row0", {out_valid[0], out_data[0]}, 9'h100);
        chk("t0_row1_v", out_valid[1], 1'b0);
        tick();
        @(negedge clk);
        chk("t1_row0", {out_valid[0], out_data[0]}, 9'h101);
        chk("t1_row1", {out_valid[1], out_data[1]}, 9'h10A);
        repeat (4) tick();
        @(negedge clk);
        chk("t5_valid", out_valid, 5'b00001);
        chk("t5_row4", out_data[4], 8'd41);
        wait_done(c1);
        chk("pass_len", c1 - c0, 6);
        tick();
        @(negedge clk);
        chk("after_done", {busy, done}, 2'b00);
    endtask

    initial begin
        int c0, c1;
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        int c0, c1;
        reset_n = 1'b0;
        start = 1'b1;
        stall = 1'b0;
        rom = '0;
        start1 = 1'b0;
        stall1 = 1'b0;
        rom1 = '0;
        #20 start = 1'b0;
        #2 reset_n = 1'b1;
        repeat (3) tick();
        @(negedge clk);
        chk("post_reset_idle", {busy, done, out_valid}, 7'h00);

        basic_pass();

        // stall of three cycles at step 2
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        c0 = cyc;
        tick();
        tick();
        stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("stall_valid", out_valid, 5'b00000);
            chk("stall_row1", out_data[1], 8'd11);
            tick();
        end
        stall = 1'b0;
        @(negedge clk);
        chk("resume_valid", out_valid, 5'b01100);
        chk("resume_row2", out_data[2], 8'd20);
        wait_done(c1);
        chk("stall_len", c1 - c0, 9);

        // start held through the pass, rom changed mid-pass
        tick();
        start = 1'b1;
        tick();
        tick();
        for (int i = 0; i < W; i++)
            for (int j = 0; j < L; j++) rom[i][j] = 8'(200 + i + j);
        @(negedge clk);
        chk("held_row1", out_data[1], 8'd10);
        wait_done(c1);
        tick();
        @(negedge clk);
        chk("held_idle", {busy, done}, 2'b00);
        tick();
        start = 1'b0;
        @(negedge clk);
        chk("held_restart", {busy, out_data[0]}, {1'b1, 8'd200});
        wait_done(c1);

        // async reset at step 3
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        #2 reset_n = 1'b0;
        #1;
        chk("async_rst", {busy, done, out_valid, out_data}, 47'h0);
        #3 reset_n = 1'b1;
        tick();
        @(negedge clk);
        chk("rst_idle", busy, 1'b0);
        basic_pass();

        // randomized traffic
        for (int k = 0; k < 1500; k++) begin
            tick();
            start = ($urandom % 3 == 0);
            stall = ($urandom % 4 == 0);
            if ($urandom % 5 == 0)
                for (int i = 0; i < W; i++)
                    for (int j = 0; j < L; j++) rom[i][j] = 8'($urandom);
            if ($urandom % 150 == 0) begin
                #2 reset_n = 1'b0;
                #1 reset_n = 1'b1;
            end
        end
        tick();
        start = 1'b0;
        stall = 1'b0;
        repeat (12) tick();

        // 1x1 instance
        rom1[0][0] = 8'hA5;
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        rom1[0][0] = 8'h11;
        @(negedge clk);
        chk("w1_feed", {busy1, out_valid1, out_data1}, 10'h3A5);
        tick();
        @(negedge clk);
        chk("w1_done", {done1, busy1, out_valid1}, 3'b100);
        tick();
        @(negedge clk);
        chk("w1_idle", {done1, busy1}, 2'b00);
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        stall1 = 1'b1;
        @(negedge clk);
        chk("w1_stall", {busy1, out_valid1, out_data1}, 10'h211);
        tick();
        @(negedge clk);
        chk("w1_hold", {busy1, done1}, 2'b10);
        stall1 = 1'b0;
        #1;
        chk("w1_resume", {out_valid1, out_data1}, 9'h111);
        tick();
        @(negedge clk);
        chk("w1_done2", {done1, busy1}, 2'b10);
        tick();
        @(negedge clk);
        chk("w1_nowrap", {done1, busy1}, 2'b00);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
